// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit, XLEN-bit datapath.
//
// One shift-add (multiply) or restoring-divide step per clock. The latency is
// fixed: valid pulses exactly XLEN cycles after acceptance, for every op and
// every operand value, including divide-by-zero and signed overflow.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   request, taken only while ready=1
//   op      funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   a, b    rs1 / rs2 operands
//   ready   unit can accept start this cycle (IDLE or DONE)
//   busy    operation in progress (CALC)
//   valid   one-cycle result strobe (DONE)
//   result  operation result, held until the next acceptance
module muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  // mc: multiplicand (multiply) or divisor (divide), magnitude only
  logic [XLEN-1:0]     mc_q, mc_d;
  // acc: {product hi, multiplier/product lo} for multiply,
  //      {unused zeros, dividend/quotient} for divide
  logic [2*XLEN-1:0]   acc_q, acc_d;
  // partial remainder; the extra bit holds the subtract borrow
  logic [XLEN:0]       rem_q, rem_d;
  logic                qneg_q, qneg_d;   // negate product / quotient
  logic                rneg_q, rneg_d;   // negate remainder (dividend sign)
  logic                div0_q, div0_d;
  logic                ovf_q, ovf_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand conditioning at acceptance
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;

  // One iteration of each datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, prod;
  logic [XLEN+1:0]   rem_sh;
  logic              div_bor;
  logic [XLEN:0]     div_dif, rem_nxt;
  logic [XLEN-1:0]   quo_nxt, quo_s, rem_s;

  always_comb begin
    a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg = a_sgn && a[XLEN-1];
    b_neg = b_sgn && b[XLEN-1];
    a_abs = a_neg ? -a : a;
    b_abs = b_neg ? -b : b;
  end

  always_comb begin
    // Right-shifting multiply: add multiplicand into the high half when the
    // current multiplier bit (acc lsb) is set, then shift the whole pair.
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mc_q} : '0);
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the difference only when it does not borrow.
    rem_sh  = {rem_q, acc_q[XLEN-1]};
    div_bor = rem_sh < {2'b00, mc_q};
    div_dif = rem_sh[XLEN:0] - {1'b0, mc_q};
    rem_nxt = div_bor ? rem_sh[XLEN:0] : div_dif;
    quo_nxt = {acc_q[XLEN-2:0], ~div_bor};

    prod  = qneg_q ? -mul_nxt : mul_nxt;
    quo_s = div0_q ? '1 : (ovf_q ? SMIN : (qneg_q ? -quo_nxt : quo_nxt));
    rem_s = ovf_q ? '0 : (rneg_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0]);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mc_d     = mc_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = op;
          mc_d    = op[2] ? b_abs : a_abs;
          acc_d   = {{XLEN{1'b0}}, (op[2] ? a_abs : b_abs)};
          rem_d   = '0;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          div0_d  = op[2] && (b == '0);
          ovf_d   = ((op == OP_DIV) || (op == OP_REM)) && (a == SMIN) && (b == '1);
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], quo_nxt};
          rem_d = rem_nxt;
        end else begin
          acc_d = mul_nxt;
        end
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = DONE;
          case (op_q)
            OP_MUL:                       result_d = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_d = quo_s;
            OP_REM, OP_REMU:              result_d = rem_s;
            default:                      result_d = result_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mc_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mc_q     <= mc_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q != CALC);
  assign busy   = (state_q == CALC);
  assign valid  = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: three instances (XLEN 8, 32, 64) sharing one clock
// and reset. Expected results are queued when an op is issued and popped when
// the instance raises valid.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start;
  logic [2:0]  op_v [3];
  logic [63:0] a_v  [3];
  logic [63:0] b_v  [3];
  wire  [2:0]  rdy, bsy, vld;
  wire  [7:0]  r8;
  wire  [31:0] r32;
  wire  [63:0] r64;
  logic [63:0] res_v [3];

  always_comb begin
    res_v[0] = {56'd0, r8};
    res_v[1] = {32'd0, r32};
    res_v[2] = r64;
  end

  int vectors = 0;
  int errors  = 0;
  logic [63:0] sb_q [$];

  muldiv_unit #(.XLEN(8)) u8 (
    .clk(clk), .reset(rst_n), .start(start[0]), .op(op_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .ready(rdy[0]), .busy(bsy[0]), .valid(vld[0]), .result(r8));

  muldiv_unit #(.XLEN(32)) u32 (
    .clk(clk), .reset(rst_n), .start(start[1]), .op(op_v[1]),
    .a(a_v[1][31:0]), .b(b_v[1][31:0]),
    .ready(rdy[1]), .busy(bsy[1]), .valid(vld[1]), .result(r32));

  muldiv_unit #(.XLEN(64)) u64 (
    .clk(clk), .reset(rst_n), .start(start[2]), .op(op_v[2]),
    .a(a_v[2]), .b(b_v[2]),
    .ready(rdy[2]), .busy(bsy[2]), .valid(vld[2]), .result(r64));

  function automatic int xl_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 32 : 64);
  endfunction

  function automatic logic [63:0] mask_of(input int k);
    return (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xl_of(k)) - 64'd1);
  endfunction

  // Behavioural reference using 128-bit arithmetic on sign/zero-extended operands.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input int xl);
    logic [127:0] msk, ua, ub, sa, sb, p, r;
    msk = (128'd1 << xl) - 128'd1;
    ua  = {64'd0, a} & msk;
    ub  = {64'd0, b} & msk;
    sa  = ua[xl-1] ? (ua | ~msk) : ua;
    sb  = ub[xl-1] ? (ub | ~msk) : ub;
    r   = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p; end
      3'd1: begin p = sa * sb; r = p >> xl; end
      3'd2: begin p = sa * ub; r = p >> xl; end
      3'd3: begin p = ua * ub; r = p >> xl; end
      3'd4: r = (ub == 0) ? msk : 128'($signed(sa) / $signed(sb));
      3'd5: r = (ub == 0) ? msk : ua / ub;
      3'd6: r = (ub == 0) ? ua  : 128'($signed(sa) % $signed(sb));
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r[63:0] & msk[63:0];
  endfunction

  function automatic logic [63:0] pick_operand(input int k);
    case ($urandom_range(0, 9))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'd1 << (xl_of(k) - 1);
      3: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Drive one request; returns just after the accepting edge with start still high.
  task automatic issue(input int k, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    start[k] = 1'b1;
    op_v[k]  = op;
    a_v[k]   = a & mask_of(k);
    b_v[k]   = b & mask_of(k);
    @(posedge clk);
  endtask

  // Count cycles from the accepting edge to the valid cycle (bounded).
  task automatic wait_done(input int k, input bit clr, output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (clr) start[k] = 1'b0;
      if (vld[k]) begin
        lat = n;
        to  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if (rdy !== 3'b111 || bsy !== 3'b000 || vld !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b bsy=%b vld=%b want 111/000/000", rdy, bsy, vld);
    end
    vectors++;
    if (r8 !== 8'd0 || r32 !== 32'd0 || r64 !== 64'd0) begin
      errors++;
      $display("FAIL reset_result got %h %h %h want 0", r8, r32, r64);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [63:0] as  [4] = '{64'd7, 64'h8000_0000, 64'h8000_0000, 64'hFFFF_FFFF};
    logic [63:0] bs  [4] = '{64'hFFFF_FFFD, 64'd2, 64'd2, 64'hFFFF_FFFF};
    logic [63:0] ex  [4] = '{64'hFFFF_FFEB, 64'hFFFF_FFFF, 64'h1, 64'hFFFF_FFFF};
    int lat; bit to; logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(1, ops[i], as[i], bs[i]);
      sb_q.push_back(ex[i]);
      wait_done(1, 1'b1, lat, to);
      e = sb_q.pop_front();
      vectors++;
      if (to || res_v[1] !== e) begin
        errors++;
        $display("FAIL mul[%0d] result got %h want %h timeout=%0d", i, res_v[1], e, to);
      end
      vectors++;
      if (lat != 32) begin
        errors++;
        $display("FAIL mul[%0d] latency got %0d want 32", i, lat);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [63:0] as  [4] = '{64'hFFFF_FFF9, 64'hFFFF_FFF9, 64'd100, 64'd100};
    logic [63:0] bs  [4] = '{64'd2, 64'd2, 64'd7, 64'd7};
    logic [63:0] ex  [4] = '{64'hFFFF_FFFD, 64'hFFFF_FFFF, 64'd14, 64'd2};
    int lat; bit to; logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(1, ops[i], as[i], bs[i]);
      sb_q.push_back(ex[i]);
      wait_done(1, 1'b1, lat, to);
      e = sb_q.pop_front();
      vectors++;
      if (to || res_v[1] !== e) begin
        errors++;
        $display("FAIL div[%0d] result got %h want %h timeout=%0d", i, res_v[1], e, to);
      end
      vectors++;
      if (lat != 32) begin
        errors++;
        $display("FAIL div[%0d] latency got %0d want 32", i, lat);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops [6] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd6, 3'd5};
    logic [63:0] as  [6] = '{64'd5, 64'd5, 64'h8000_0000, 64'h8000_0000, 64'hFFFF_FFFB, 64'd9};
    logic [63:0] bs  [6] = '{64'd0, 64'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 64'd0};
    logic [63:0] ex  [6] = '{64'hFFFF_FFFF, 64'd5, 64'h8000_0000, 64'd0, 64'hFFFF_FFFB, 64'hFFFF_FFFF};
    int lat; bit to; logic [63:0] e;
    for (int i = 0; i < 6; i++) begin
      issue(1, ops[i], as[i], bs[i]);
      sb_q.push_back(ex[i]);
      wait_done(1, 1'b1, lat, to);
      e = sb_q.pop_front();
      vectors++;
      if (to || res_v[1] !== e) begin
        errors++;
        $display("FAIL special[%0d] result got %h want %h timeout=%0d", i, res_v[1], e, to);
      end
      vectors++;
      if (lat != 32) begin
        errors++;
        $display("FAIL special[%0d] latency got %0d want 32", i, lat);
      end
    end
  endtask

  // start stays high for the whole first op while operands churn; the second
  // op is whatever sits on the inputs in the DONE cycle.
  task automatic test_back_to_back;
    int lat; bit to; logic [63:0] e;
    issue(1, 3'd0, 64'd1234, 64'd5678);
    sb_q.push_back(64'd7006652);
    sb_q.push_back(64'd142);
    lat = 0; to = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n < 20) begin
        a_v[1]  = {32'd0, $urandom};
        b_v[1]  = {32'd0, $urandom};
        op_v[1] = 3'($urandom_range(0, 7));
      end else begin
        op_v[1] = 3'd5;
        a_v[1]  = 64'd1000;
        b_v[1]  = 64'd7;
      end
      if (n == 5) begin
        vectors++;
        if (bsy[1] !== 1'b1 || rdy[1] !== 1'b0) begin
          errors++;
          $display("FAIL hold_busy got busy=%b ready=%b want 1/0", bsy[1], rdy[1]);
        end
      end
      if (vld[1]) begin
        lat = n;
        to  = 1'b0;
        break;
      end
    end
    e = sb_q.pop_front();
    vectors++;
    if (to || res_v[1] !== e) begin
      errors++;
      $display("FAIL b2b_first result got %h want %h timeout=%0d", res_v[1], e, to);
    end
    vectors++;
    if (lat != 32) begin
      errors++;
      $display("FAIL b2b_first latency got %0d want 32", lat);
    end
    @(posedge clk);
    wait_done(1, 1'b1, lat, to);
    e = sb_q.pop_front();
    vectors++;
    if (to || res_v[1] !== e) begin
      errors++;
      $display("FAIL b2b_second result got %h want %h timeout=%0d", res_v[1], e, to);
    end
    vectors++;
    if (lat != 32) begin
      errors++;
      $display("FAIL b2b_second latency got %0d want 32", lat);
    end
  endtask

  task automatic test_abort;
    int stray;
    issue(1, 3'd0, 64'h1234, 64'h5678);
    repeat (10) begin
      @(negedge clk);
      start[1] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rdy[1] !== 1'b1 || bsy[1] !== 1'b0 || vld[1] !== 1'b0 || r32 !== 32'd0) begin
      errors++;
      $display("FAIL abort got rdy=%b bsy=%b vld=%b res=%h want 1/0/0/0",
               rdy[1], bsy[1], vld[1], r32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (vld[1]) stray++;
    end
    vectors++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_stray_valid got %0d pulses want 0", stray);
    end
  endtask

  task automatic test_xlen8;
    logic [2:0]  ops [2] = '{3'd3, 3'd4};
    logic [63:0] as  [2] = '{64'hFF, 64'h80};
    logic [63:0] bs  [2] = '{64'hFF, 64'hFF};
    logic [63:0] ex  [2] = '{64'hFE, 64'h80};
    int lat; bit to; logic [63:0] e;
    for (int i = 0; i < 2; i++) begin
      issue(0, ops[i], as[i], bs[i]);
      sb_q.push_back(ex[i]);
      wait_done(0, 1'b1, lat, to);
      e = sb_q.pop_front();
      vectors++;
      if (to || res_v[0] !== e) begin
        errors++;
        $display("FAIL xlen8[%0d] result got %h want %h timeout=%0d", i, res_v[0], e, to);
      end
      vectors++;
      if (lat != 8) begin
        errors++;
        $display("FAIL xlen8[%0d] latency got %0d want 8", i, lat);
      end
    end
  endtask

  task automatic test_random(input int k);
    logic [63:0] q [$];
    logic [63:0] e;
    int lat; bit to; int fails;
    fails = 0;
    for (int i = 0; i < 1000; i++) begin
      issue(k, 3'($urandom_range(0, 7)), pick_operand(k), pick_operand(k));
      q.push_back(model(op_v[k], a_v[k], b_v[k], xl_of(k)));
      wait_done(k, 1'b1, lat, to);
      e = q.pop_front();
      vectors++;
      if (to || res_v[k] !== e || lat != xl_of(k)) begin
        errors++;
        fails++;
        if (fails <= 10)
          $display("FAIL random_x%0d[%0d] op=%0d a=%h b=%h got %h lat %0d want %h lat %0d",
                   xl_of(k), i, op_v[k], a_v[k], b_v[k], res_v[k], lat, e, xl_of(k));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 3'b000;
    for (int k = 0; k < 3; k++) begin
      op_v[k] = 3'd0;
      a_v[k]  = 64'd0;
      b_v[k]  = 64'd0;
    end
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_back_to_back;
    test_abort;
    test_xlen8;
    fork
      test_random(0);
      test_random(1);
      test_random(2);
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit implementing the RV32M operation set, generalised to an XLEN-bit datapath. It sits beside the single-cycle ALU in the execute stage. The CPU issues an operation with a start/ready handshake, stalls while busy, and takes the result on a one-cycle valid pulse. It performs one shift-add or restoring-divide step per clock and has a fixed, data-independent latency.

Parameters:
XLEN, 32, operand and result width in bits; legal values are 8, 16, 32 and 64.
CNT_W, $clog2(XLEN), width of the iteration counter; derived, not to be overridden.

Ports:
clk  input  1  clock; rising-edge active
reset  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when ready=1
op  input  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=DIV 5=DIVU 6=REM 7=REMU (funct3 encoding)
a  input  XLEN  rs1 operand (multiplicand/dividend)
b  input  XLEN  rs2 operand (multiplier/divisor)
ready  output  1  unit can accept start this cycle
busy  output  1  operation in progress
valid  output  1  one-cycle pulse; result is valid
result  output  XLEN  operation result; held until the next acceptance

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, all internal registers 0, ready=1, busy=0, valid=0, result=0. An assertion mid-operation aborts the operation with no valid pulse. The first acceptance is possible on the first rising edge after reset deasserts.
- FSM states are IDLE, CALC and DONE. ready=1 in IDLE and DONE. busy=1 in CALC only. valid=1 in DONE only.
- Acceptance edge E0 (start=1 and ready=1):
  - Latch op.
  - Latch the absolute values of a and b per signedness: MULH both signed, MULHSU a signed only, DIV/REM both signed, all others unsigned.
  - Latch the result sign flag and the special-case flags.
  - counter=0; go to CALC.
- CALC: one iteration per edge. counter increments each edge.
  - Multiply: 2*XLEN-bit shift-add.
  - Divide: restoring, one quotient bit per edge.
  - On the edge where counter==XLEN-1, the final iteration completes. On that edge: apply sign correction (two's-complement negate), select the output, register result, and go to DONE.
- Latency: valid is high in the cycle following edge E0+XLEN, i.e. exactly XLEN cycles after acceptance, for every op and every operand value.
- DONE lasts one cycle.
  - start=1 in DONE is accepted (back-to-back issue): go to CALC; valid drops.
  - Otherwise go to IDLE; result is held.
- start while busy is ignored, with no side effects. Changes to a, b or op after E0 do not affect the operation in flight.
- Result selection:
  - MUL returns the low XLEN bits of the product.
  - MULH, MULHSU and MULHU return the high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
- Division special cases (same fixed latency):
  - b=0: DIV and DIVU return all ones; REM and REMU return a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): DIV returns a; REM returns 0.
- Signed division truncates toward zero. The remainder takes the sign of the dividend.
- Sign correction is applied modulo 2^(2*XLEN) for multiply and modulo 2^XLEN for divide. No wider intermediate is exposed.
- The internal remainder register is XLEN+1 bits to hold the subtract borrow.

Test Plan:
- Reset: reset=0 mid-CALC (10 cycles after a MUL start) -> ready=1, busy=0, valid=0, result=0 immediately. After reset=1 there is no stray valid pulse.
- MUL/MULH (XLEN=32):
  - a=7, b=-3 MUL -> result=32'hFFFFFFEB, with valid exactly 32 cycles after acceptance.
  - a=32'h80000000, b=2 MULH -> 32'hFFFFFFFF.
  - Same operands MULHU -> 32'h00000001.
  - MULHSU a=-1, b=32'hFFFFFFFF -> 32'hFFFFFFFF.
- Division:
  - DIV a=-7, b=2 -> 32'hFFFFFFFD (-3).
  - REM a=-7, b=2 -> 32'hFFFFFFFF (-1).
  - DIVU a=100, b=7 -> 14.
  - REMU a=100, b=7 -> 2.
- Special cases:
  - DIV a=5, b=0 -> 32'hFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - DIV a=32'h80000000, b=-1 -> 32'h80000000.
  - REM with the same operands -> 0.
  - All four complete in 32 cycles.
- Handshake: start held high through the whole op with a and b changed during CALC -> busy=1, ready=0, the in-flight result is unaffected. A second op with start=1 in the DONE cycle is accepted, and its valid pulse arrives 32 cycles later.
- Parameter sweep: XLEN=8 run with MULHU 255×255 -> 8'hFE; DIV -128/-1 -> 8'h80. Latency is 8 cycles. Every op is checked against a behavioural model over 1000 random operand pairs at XLEN=8, 32 and 64.
